// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache-subsystem types and constants
//
// Purpose: state encoding for the memory wait-state FSM, MRW encoding and the
// default bus widths shared by the cache controller and main-memory model.
package cache_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 32;

  localparam logic MRW_READ  = 1'b0;
  localparam logic MRW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word array, synchronous write, registered read
//
// Purpose: backing store for mem_wait_ctrl.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (clears only the read register)
//   we     - write enable; wdata is stored at addr on the rising edge
//   re     - read enable; rdata loads array[addr] on the rising edge
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data, holds until the next read
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - main-memory model with programmable wait states
//
// Purpose: accepts a one-cycle request from the cache controller, waits
// WAIT_CYCLES cycles, then completes it against mem_array and pulses MDone.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   MStrobe  - one-cycle request strobe, sampled only in IDLE
//   MRW      - 1 = write, 0 = read, sampled with MStrobe
//   MAddr    - word address, sampled with MStrobe
//   MDataIn  - write data, sampled with MStrobe
//   MDataOut - read data, valid while MDone=1 on a read; holds otherwise
//   MDone    - one-cycle completion pulse
//   MBusy    - high from the cycle after capture through the MDone cycle
//   ProtoErr - sticky: MStrobe seen while busy
module mem_wait_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MDone,
  output logic              MBusy,
  output logic              ProtoErr
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
      $error("mem_wait_ctrl: WAIT_CYCLES must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] CNT_INIT = 8'(WAIT_CYCLES - 1);

  mem_state_t        state;
  logic [7:0]        cnt;
  logic              cap_rw;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;

  logic arr_we;
  logic arr_re;

  // The read is launched on the WAIT->XFER edge so data appears with MDone;
  // the write commits on the XFER exit edge, ahead of any following read.
  assign arr_re = (state == WAIT) && (cnt == 8'd0) && (cap_rw == MRW_READ);
  assign arr_we = (state == XFER) && (cap_rw == MRW_WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      cap_rw   <= MRW_READ;
      cap_addr <= '0;
      cap_data <= '0;
      MDone    <= 1'b0;
      MBusy    <= 1'b0;
      ProtoErr <= 1'b0;
    end else begin
      MDone <= 1'b0;
      if (MStrobe && state != IDLE) ProtoErr <= 1'b1;
      case (state)
        IDLE: begin
          if (MStrobe) begin
            cap_rw   <= MRW;
            cap_addr <= MAddr;
            cap_data <= MDataIn;
            cnt      <= CNT_INIT;
            MBusy    <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            MDone <= 1'b1;
            state <= XFER;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        XFER: begin
          MBusy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          MBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (cap_addr),
    .wdata (cap_data),
    .rdata (MDataOut)
  );

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb/tb_mem_wait_ctrl.sv - scoreboard bench for mem_wait_ctrl (WAIT_CYCLES 4 and 1)
module tb_mem_wait_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic        s4, rw4, s1, rw1;
  logic [7:0]  a4, a1;
  logic [31:0] di4, di1, do4, do1;
  logic        done4, busy4, perr4, done1, busy1, perr1;

  mem_wait_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .MStrobe(s4), .MRW(rw4), .MAddr(a4),
    .MDataIn(di4), .MDataOut(do4), .MDone(done4), .MBusy(busy4), .ProtoErr(perr4)
  );

  mem_wait_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .MStrobe(s1), .MRW(rw1), .MAddr(a1),
    .MDataIn(di1), .MDataOut(do1), .MDone(done1), .MBusy(busy1), .ProtoErr(perr1)
  );

  typedef struct {
    int          done_cyc;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the WAIT_CYCLES=4 instance.
  logic [31:0] last_rd4 = 32'h0;
  int          busy_run4 = 0;
  always @(negedge clk) begin
    if (!reset) begin
      busy_run4 = 0;
      last_rd4  = 32'h0;
    end else begin
      if (busy4) busy_run4++;
      else if (busy_run4 > 0) begin
        chk("busy_len4", busy_run4, 5);
        busy_run4 = 0;
      end
      if (done4) begin
        if (q4.size() == 0) chk("unexpected_done4", 1, 0);
        else begin
          exp_t e;
          e = q4.pop_front();
          chk("latency4", cyc, e.done_cyc);
          if (e.is_rd) begin
            chk("rdata4", do4, e.data);
            last_rd4 = e.data;
          end else begin
            chk("hold_on_write4", do4, last_rd4);
          end
        end
      end
    end
  end

  // Monitor for the WAIT_CYCLES=1 instance.
  int busy_run1 = 0;
  always @(negedge clk) begin
    if (!reset) busy_run1 = 0;
    else begin
      if (busy1) busy_run1++;
      else if (busy_run1 > 0) begin
        chk("busy_len1", busy_run1, 2);
        busy_run1 = 0;
      end
      if (done1) begin
        if (q1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk("latency1", cyc, e.done_cyc);
          if (e.is_rd) chk("rdata1", do1, e.data);
        end
      end
    end
  end

  // Strobe on the next negedge; inputs are scrambled after capture to show
  // that only the captured values matter.
  task automatic issue4(input logic rw, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit track);
    exp_t e;
    @(negedge clk);
    s4 = 1'b1; rw4 = rw; a4 = a; di4 = d;
    e.done_cyc = cyc + 1 + 4;
    e.is_rd    = (rw == 1'b0);
    e.data     = exp_rd;
    if (track) q4.push_back(e);
    @(negedge clk);
    s4 = 1'b0; rw4 = ~rw; a4 = ~a; di4 = 32'hFFFF_FFFF;
    chk("accept_busy4", busy4, 1'b1);
  endtask

  task automatic issue1(input logic rw, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    exp_t e;
    @(negedge clk);
    s1 = 1'b1; rw1 = rw; a1 = a; di1 = d;
    e.done_cyc = cyc + 1 + 1;
    e.is_rd    = (rw == 1'b0);
    e.data     = exp_rd;
    q1.push_back(e);
    @(negedge clk);
    s1 = 1'b0; rw1 = ~rw; a1 = ~a; di1 = 32'hFFFF_FFFF;
    chk("accept_busy1", busy1, 1'b1);
  endtask

  // Returns at the negedge where MDone is high, so the next issue strobes
  // on the first IDLE cycle.
  task automatic wait_done4();
    for (int i = 0; i < 30; i++) begin
      if (done4) return;
      @(negedge clk);
    end
    chk("timeout_done4", 1, 0);
  endtask

  task automatic wait_done1();
    for (int i = 0; i < 30; i++) begin
      if (done1) return;
      @(negedge clk);
    end
    chk("timeout_done1", 1, 0);
  endtask

  initial begin
    s4 = 0; rw4 = 0; a4 = 0; di4 = 0;
    s1 = 0; rw1 = 0; a1 = 0; di1 = 0;

    #3 reset = 1'b0;
    #1;
    chk("rst_done4", done4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_dout4", do4, 0);
    chk("rst_perr4", perr4, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Write then read.
    issue4(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b1);
    wait_done4();
    issue4(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    wait_done4();

    // Back-to-back writes, then reads.
    issue4(1'b1, 8'h01, 32'h1, 32'h0, 1'b1);
    wait_done4();
    issue4(1'b1, 8'h02, 32'h2, 32'h0, 1'b1);
    wait_done4();
    issue4(1'b0, 8'h01, 32'h0, 32'h1, 1'b1);
    wait_done4();
    issue4(1'b0, 8'h02, 32'h0, 32'h2, 1'b1);
    wait_done4();

    // Strobe while busy.
    issue4(1'b1, 8'h20, 32'h12345678, 32'h0, 1'b1);
    wait_done4();
    chk("perr_clear", perr4, 0);
    issue4(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1);
    s4 = 1'b1; rw4 = 1'b1; a4 = 8'h20; di4 = 32'hBAD;
    @(negedge clk);
    s4 = 1'b0;
    chk("perr_set", perr4, 1);
    wait_done4();
    issue4(1'b0, 8'h20, 32'h0, 32'h12345678, 1'b1);
    wait_done4();
    chk("perr_sticky", perr4, 1);

    // Reset mid-access aborts the write.
    issue4(1'b1, 8'h30, 32'h0, 32'h0, 1'b1);
    wait_done4();
    issue4(1'b1, 8'h30, 32'hCAFE, 32'h0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_done4", done4, 0);
    chk("mid_rst_busy4", busy4, 0);
    chk("mid_rst_dout4", do4, 0);
    chk("mid_rst_perr4", perr4, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_done_after_abort", done4, 0);
    issue4(1'b0, 8'h30, 32'h0, 32'h0, 1'b1);
    wait_done4();

    // WAIT_CYCLES=1 instance.
    issue1(1'b1, 8'h05, 32'hA5A5_5A5A, 32'h0);
    wait_done1();
    issue1(1'b0, 8'h05, 32'h0, 32'hA5A5_5A5A);
    wait_done1();
    @(negedge clk);
    chk("done1_fell", done1, 0);
    chk("dout1_hold", do1, 32'hA5A5_5A5A);
    @(negedge clk);
    chk("dout1_hold2", do1, 32'hA5A5_5A5A);

    repeat (4) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
